// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_sequencer_pkg;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiplier and restoring divider datapath
// Outputs are the post-step values so the controller can capture the result on the final step edge.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_init,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;

  logic [2*WIDTH-1:0] w_acc_nx;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quot_nx;

  assign w_acc_nx  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Partial remainder is always below the divisor, so one extra bit holds the shifted value.
  assign w_shift   = {r_rem, r_quot[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_divisor};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nx  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_nx = {r_quot[WIDTH-2:0], w_qbit};

  assign o_prod = w_acc_nx;
  assign o_quot = w_quot_nx;
  assign o_rem  = w_rem_nx;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (i_init) begin
      r_acc     <= '0;
      r_mcand   <= {{WIDTH{1'b0}}, i_a};
      r_mplier  <= i_b;
      r_rem     <= '0;
      r_quot    <= i_a;
      r_divisor <= i_b;
    end else if (i_step) begin
      if (i_div) begin
        r_rem  <= w_rem_nx;
        r_quot <= w_quot_nx;
      end else begin
        r_acc    <= w_acc_nx;
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - EX-stage RV32M controller: stalls while iterating, holds result until acked
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic             i_signed1,
  input  logic             i_signed2,
  input  logic             i_half_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_kill,
  input  logic             i_result_ack,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_valid
);

  localparam int unsigned      CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_MIN  = SIGNED_MIN[31 -: WIDTH];
  localparam logic [WIDTH-1:0] W_ONES = DIV_BY_ZERO_Q[31 -: WIDTH];

  md_state_t          r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_res, r_neg_rem, r_half_sel, r_rem_sel;
  logic [WIDTH-1:0]   r_result, w_result_d;
  logic               r_result_valid, w_valid_d;
  logic               w_accept, w_iter_init, w_iter_step;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_quot, w_rem, w_quot_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic               w_b_zero, w_ovf;

  assign w_a_abs    = (i_signed1 & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_abs    = (i_signed2 & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_b_zero   = (i_b == '0);
  assign w_ovf      = ((i_funct3 == F3_DIV) | (i_funct3 == F3_REM)) & (i_a == W_MIN) & (i_b == W_ONES);
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quot_fix = r_neg_res ? -w_quot : w_quot;
  assign w_rem_fix  = r_neg_rem ? -w_rem : w_rem;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_init (w_iter_init),
    .i_step (w_iter_step),
    .i_div  (r_state == DIV),
    .i_a    (w_a_abs),
    .i_b    (w_b_abs),
    .o_prod (w_prod),
    .o_quot (w_quot),
    .o_rem  (w_rem)
  );

  always_comb begin
    w_state_next = r_state;
    w_valid_d    = r_result_valid;
    w_result_d   = r_result;
    w_accept     = 1'b0;
    w_iter_init  = 1'b0;
    w_iter_step  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start && !i_kill) begin
          w_accept = 1'b1;
          // Divide-by-zero and signed overflow have fixed answers and skip iteration.
          if (i_funct3[2] && w_b_zero) begin
            w_state_next = DONE;
            w_valid_d    = 1'b1;
            w_result_d   = i_funct3[1] ? i_a : W_ONES;
          end else if (w_ovf) begin
            w_state_next = DONE;
            w_valid_d    = 1'b1;
            w_result_d   = i_funct3[1] ? '0 : W_MIN;
          end else begin
            w_iter_init  = 1'b1;
            w_state_next = i_funct3[2] ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (i_kill) begin
          w_state_next = IDLE;
        end else begin
          w_iter_step = 1'b1;
          if (r_cnt == LAST) begin
            w_state_next = DONE;
            w_valid_d    = 1'b1;
            if (r_state == MUL)
              w_result_d = r_half_sel ? w_prod_fix[2*WIDTH-1:WIDTH] : w_prod_fix[WIDTH-1:0];
            else
              w_result_d = r_rem_sel ? w_rem_fix : w_quot_fix;
          end
        end
      end
      DONE: begin
        if (i_kill || i_result_ack) begin
          w_state_next = IDLE;
          w_valid_d    = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt          <= '0;
      r_neg_res      <= 1'b0;
      r_neg_rem      <= 1'b0;
      r_half_sel     <= 1'b0;
      r_rem_sel      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result       <= w_result_d;
      r_result_valid <= w_valid_d;
      if (w_accept) begin
        r_cnt      <= '0;
        r_neg_res  <= (i_signed1 & i_a[WIDTH-1]) ^ (i_signed2 & i_b[WIDTH-1]);
        r_neg_rem  <= i_signed1 & i_a[WIDTH-1];
        r_half_sel <= i_half_sel;
        r_rem_sel  <= i_funct3[1];
      end else if (w_iter_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stall        = i_rst & ~i_kill &
                          (((r_state == IDLE) & i_start) | (r_state == MUL) | (r_state == DIV));
  assign o_busy         = (r_state == MUL) | (r_state == DIV);
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed table-driven bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        s1;
    logic        s2;
    logic        hs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        signed1 = 1'b0;
  logic        signed2 = 1'b0;
  logic        half_sel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        kill = 1'b0;
  logic        result_ack = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_funct3       (funct3),
    .i_signed1      (signed1),
    .i_signed2      (signed2),
    .i_half_sel     (half_sel),
    .i_a            (a),
    .i_b            (b),
    .i_kill         (kill),
    .i_result_ack   (result_ack),
    .o_stall        (stall),
    .o_busy         (busy),
    .o_result       (result),
    .o_result_valid (result_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] f3, input logic s1, input logic s2,
                              input logic hs, input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = name; v.f3 = f3; v.s1 = s1; v.s2 = s2; v.hs = hs;
    v.a = va; v.b = vb; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Issues one op with start held high and leaves the DUT in DONE (start still high).
  task automatic run_op(input vec_t v);
    int edges;
    int stall_cnt;
    logic busy_seen;
    edges = 0; stall_cnt = 0; busy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; funct3 = v.f3; signed1 = v.s1; signed2 = v.s2; half_sel = v.hs;
    a = v.a; b = v.b;
    #1;
    while (!result_valid && edges < 50) begin
      if (stall) stall_cnt++;
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_seen = 1'b1;
      if (edges == 1) begin
        // Operands are latched at acceptance; scramble them to prove it.
        a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
    end
    chk({v.name, " result"}, result, v.exp);
    chk({v.name, " latency"}, 32'(edges), 32'(v.lat));
    chk({v.name, " stall cycles"}, 32'(stall_cnt), 32'(v.lat));
    chk({v.name, " busy seen"}, {31'b0, busy_seen}, {31'b0, v.lat > 1});
    chk({v.name, " stall in DONE"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic ack_done(input string name);
    logic [31:0] held;
    held = result;
    @(negedge clk);
    start = 1'b0; result_ack = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " valid after ack"}, {31'b0, result_valid}, 32'd0);
    chk({name, " result kept after ack"}, result, held);
    result_ack = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] held;
    vecs[0]  = mk("mul neg",        F3_MUL,    1, 1, 0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    vecs[1]  = mk("mulh min*min",   F3_MULH,   1, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    vecs[2]  = mk("mulhu max*max",  F3_MULHU,  0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    vecs[3]  = mk("mulhsu -1*max",  F3_MULHSU, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    vecs[4]  = mk("div -7/2",       F3_DIV,    1, 1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    vecs[5]  = mk("rem -7/2",       F3_REM,    1, 1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    vecs[6]  = mk("divu",           F3_DIVU,   0, 0, 0, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 33);
    vecs[7]  = mk("remu 100/7",     F3_REMU,   0, 0, 0, 32'd100,       32'd7,         32'd2,         33);
    vecs[8]  = mk("div by zero",    F3_DIV,    1, 1, 0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    vecs[9]  = mk("remu by zero",   F3_REMU,   0, 0, 0, 32'd5,         32'd0,         32'd5,         1);
    vecs[10] = mk("div overflow",   F3_DIV,    1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    vecs[11] = mk("rem overflow",   F3_REM,    1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    vecs[12] = mk("rem -100/7",     F3_REM,    1, 1, 0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33);
    vecs[13] = mk("div 100/-7",     F3_DIV,    1, 1, 0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    vecs[14] = mk("mulh -1*-1",     F3_MULH,   1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33);
    vecs[15] = mk("mul lo 2^16sq",  F3_MUL,    0, 0, 0, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 33);

    // Reset state, with start asserted to show stall is suppressed while in reset.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset valid", {31'b0, result_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i]);
      ack_done(vecs[i].name);
    end

    // Kill during MUL at E10, then a fresh op must run normally.
    @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; signed1 = 1; signed2 = 1; half_sel = 0; a = 32'd7; b = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    chk("busy before kill", {31'b0, busy}, 32'd1);
    @(negedge clk);
    kill = 1'b1; start = 1'b0;
    #1;
    chk("stall during kill", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("busy after kill", {31'b0, busy}, 32'd0);
    chk("valid after kill", {31'b0, result_valid}, 32'd0);
    kill = 1'b0;
    #1;
    chk("stall after kill", {31'b0, stall}, 32'd0);
    run_op(mk("divu 9/3 post-kill", F3_DIVU, 0, 0, 0, 32'd9, 32'd3, 32'd3, 33));

    // DONE holds with start high and no ack: no re-issue, no stall.
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("done hold result", result, held);
      chk("done hold valid", {31'b0, result_valid}, 32'd1);
      chk("done hold busy", {31'b0, busy}, 32'd0);
      chk("done hold stall", {31'b0, stall}, 32'd0);
    end
    ack_done("done hold");

    // kill together with start in IDLE: start is not accepted.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = F3_DIVU; a = 32'd9; b = 32'd0;
    #1;
    chk("idle kill stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle kill valid", {31'b0, result_valid}, 32'd0);
    chk("idle kill busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    kill = 1'b0; start = 1'b0;

    // Reset in the middle of a DIV at E15.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; signed1 = 1; signed2 = 1; a = 32'd1000; b = 32'd7;
    repeat (15) @(posedge clk);
    #1;
    chk("busy before reset", {31'b0, busy}, 32'd1);
    chk("result before reset", result, 32'd3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midop reset result", result, 32'd0);
    chk("midop reset valid", {31'b0, result_valid}, 32'd0);
    chk("midop reset busy", {31'b0, busy}, 32'd0);
    chk("midop reset stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    chk("post reset busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
